// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter
// Host-to-device PS/2 byte sender. It drives the open-drain pull-low enables
// for the mouse clock and data lines: it inhibits the bus, issues a request
// to send, shifts out one frame on the device's clock, checks the device
// acknowledge, and then waits for the bus to go idle.
// Optional feature macro: PS2_TX_TIMEOUT_EN. When it is defined, a watchdog
// aborts the frame if the device stops clocking.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 5000
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 100000
`endif
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    output logic       CLK_MOUSE_OE,
    output logic       DATA_MOUSE_OE,
    input  logic       SEND_BYTE,
    input  logic [7:0] BYTE_TO_SEND,
    output logic       BUSY,
    output logic       BYTE_SENT,
    output logic       TX_ERROR
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        RELEASE
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]       clk_sync_reg;
    logic [1:0]       data_sync_reg;
    logic             clk_prev_reg;
    logic             clk_synced;
    logic             data_synced;
    logic             fall;

    logic [9:0]       frame_reg;
    logic [3:0]       bit_cnt_reg;
    logic [INH_W-1:0] inh_cnt_reg;
    logic             data_oe_reg;
    logic             ok_reg;
    logic             byte_sent_reg;
    logic             tx_error_reg;

    logic             release_done;
    logic             timeout_hit;

    assign clk_synced   = clk_sync_reg[1];
    assign data_synced  = data_sync_reg[1];
    assign fall         = clk_prev_reg & ~clk_synced;
    assign release_done = (state_reg == RELEASE) & clk_synced & data_synced;

    // Two-flop synchronisers for both pins plus the previous synced clock
    // for falling-edge detection. They reset high, the idle bus level.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            clk_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], CLK_MOUSE_IN};
            data_sync_reg <= {data_sync_reg[0], DATA_MOUSE_IN};
            clk_prev_reg  <= clk_sync_reg[1];
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            in_wait;

    assign in_wait = (state_reg == SEND) | (state_reg == ACK) | (state_reg == RELEASE);
    assign timeout_hit = in_wait & ~fall & ~release_done &
                         (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts cycles since the last device clock fall while the
    // device owns the clock. It saturates and clears outside those states.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wd_cnt_reg <= '0;
        end else if (!in_wait || fall) begin
            wd_cnt_reg <= '0;
        end else if (wd_cnt_reg != WD_W'(TIMEOUT_CYCLES)) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. The watchdog overrides every wait state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (SEND_BYTE) state_next = INHIBIT;
            INHIBIT: if (inh_cnt_reg == INH_W'(INHIBIT_CYCLES - 1)) state_next = REQ;
            REQ:     state_next = SEND;
            SEND:    if (fall && bit_cnt_reg == 4'd9) state_next = ACK;
            ACK:     if (fall) state_next = RELEASE;
            RELEASE: if (release_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (timeout_hit) begin
            state_next = IDLE;
        end
    end

    // Datapath: frame capture, inhibit and bit counters, registered data
    // enable, acknowledge flag and the single-cycle completion pulses.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame_reg     <= '0;
            bit_cnt_reg   <= '0;
            inh_cnt_reg   <= '0;
            data_oe_reg   <= 1'b0;
            ok_reg        <= 1'b0;
            byte_sent_reg <= 1'b0;
            tx_error_reg  <= 1'b0;
        end else begin
            byte_sent_reg <= 1'b0;
            tx_error_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    data_oe_reg <= 1'b0;
                    if (SEND_BYTE) begin
                        frame_reg   <= {1'b1, ~^BYTE_TO_SEND, BYTE_TO_SEND};
                        inh_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                        ok_reg      <= 1'b0;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt_reg != INH_W'(INHIBIT_CYCLES)) begin
                        inh_cnt_reg <= inh_cnt_reg + 1'b1;
                    end
                end
                REQ: begin
                    // The start bit is held until the first device clock fall.
                    data_oe_reg <= 1'b1;
                end
                SEND: begin
                    if (fall) begin
                        data_oe_reg <= ~frame_reg[bit_cnt_reg];
                        if (bit_cnt_reg != 4'd9) begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                ACK: begin
                    data_oe_reg <= 1'b0;
                    if (fall) begin
                        ok_reg <= ~data_synced;
                    end
                end
                RELEASE: begin
                    if (release_done) begin
                        byte_sent_reg <= ok_reg;
                        tx_error_reg  <= ~ok_reg;
                    end
                end
                default: data_oe_reg <= 1'b0;
            endcase
            if (timeout_hit) begin
                byte_sent_reg <= 1'b0;
                tx_error_reg  <= 1'b1;
                data_oe_reg   <= 1'b0;
            end
        end
    end

    // Outputs decoded from the state so that reset releases the lines at once.
    always_comb begin
        CLK_MOUSE_OE  = (state_reg == INHIBIT) | (state_reg == REQ);
        DATA_MOUSE_OE = (state_reg == REQ) | ((state_reg == SEND) & data_oe_reg);
        BUSY          = (state_reg != IDLE);
        BYTE_SENT     = byte_sent_reg;
        TX_ERROR      = tx_error_reg;
    end

endmodule
